receptor_hamming: RTL and testbench
===================================

Name: receptor_hamming

Overview:
- Upstream neighbour of the Hamming(7,4) correction stage.
- Deserialises a 7-bit Hamming codeword from a strobed serial line and computes the 3-bit syndrome.
- Presents {dataRaw, sindrome} to the correction stage through a one-deep valid/ready output buffer.
- Flags overflow and inter-bit timeout, and counts frames that arrive with a nonzero syndrome.

Parameters:
- TIMEOUT_CYCLES, 1000: cycles without bitValid while mid-frame before the partial frame is aborted.
- ERR_CNT_W, 8: width of the saturating errCount.

Ports:
- clk  in  1  system clock; single clock domain, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- serialIn  in  1  serial codeword bit, sampled only when bitValid=1.
- bitValid  in  1  one-cycle strobe qualifying serialIn.
- frameStart  in  1  forces frame resync; discards any partial frame.
- dataRaw  out  7  captured codeword; index i = Hamming position i+1.
- sindrome  out  3  {s2,s1,s0}; value = erroneous position, 0 = no error.
- salidaValida  out  1  output buffer holds an unconsumed frame.
- salidaLista  in  1  downstream ready.
- ocupado  out  1  high while in RECIBIENDO.
- overflow  out  1  sticky; a completed frame was dropped.
- timeoutErr  out  1  one-cycle pulse on timeout abort.
- errCount  out  ERR_CNT_W  saturating count of accepted frames with sindrome != 0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; bitCount, idleCount and the shift register cleared.
  - All outputs 0: dataRaw, sindrome, salidaValida, ocupado, overflow, timeoutErr, errCount.
- Bit order: LSB first. The first sampled bit goes to index 0, the seventh to index 6.
- FSM states: IDLE, RECIBIENDO.
  - IDLE, bitValid=1: store bit at index 0, bitCount=1, go to RECIBIENDO.
  - RECIBIENDO, bitValid=1 with bitCount<6: store bit at index bitCount, increment bitCount, clear idleCount.
  - RECIBIENDO, bitValid=1 with bitCount==6: frame complete; go to IDLE.
  - RECIBIENDO, no bitValid: increment idleCount. At idleCount==TIMEOUT_CYCLES-1, go to IDLE, discard the partial frame, pulse timeoutErr for exactly one cycle.
- frameStart:
  - Has priority over the FSM: go to IDLE, clear bitCount and idleCount.
  - If bitValid is high in the same cycle, that bit becomes bit 0 of the new frame (RECIBIENDO, bitCount=1).
  - Does not affect the output buffer or flags.
- Syndrome, computed on the complete word w including the bit just sampled:
  - s0 = w0^w2^w4^w6
  - s1 = w1^w2^w5^w6
  - s2 = w3^w4^w5^w6
- Frame-complete edge:
  - Load dataRaw and sindrome and set salidaValida if (salidaValida==0 || salidaLista==1).
  - Latency: visible the cycle after the 7th bitValid.
  - If salidaValida==1 and salidaLista==0: drop the new frame, keep buffer contents, set overflow.
- Output handshake:
  - dataRaw and sindrome stay stable while salidaValida=1.
  - A transfer happens on any edge where salidaValida && salidaLista. salidaValida clears unless a new frame loads on the same edge; in that case it stays 1 with the new data.
- errCount: increments by 1 on each load with sindrome != 0. Saturates at 2^ERR_CNT_W-1. Dropped frames are not counted.
- overflow and errCount clear only on reset.
- ocupado = (state==RECIBIENDO), registered.
- Reset mid-frame or mid-handshake: everything returns immediately to reset values; the partial frame is lost.

Test Plan:
- Clean frame: send serial 1,0,1,0,1,0,1 (7'b1010101, data 1011), salidaLista=1. Expected: dataRaw=7'b1010101, sindrome=3'b000, salidaValida high for 1 cycle, errCount=0.
- Single-bit error: send 7'b1000101 (index 4 flipped). Expected: sindrome=3'b101, errCount=1; correction stage then outputs 4'b1011.
- Backpressure and overflow:
  - Hold salidaLista=0 and send two frames (1010101, then 0000000). Expected: first frame held, overflow=1, second frame dropped, errCount unchanged.
  - Then raise salidaLista. Expected: salidaValida falls next edge.
- Timeout: send 3 bits, then idle TIMEOUT_CYCLES cycles. Expected: one-cycle timeoutErr pulse, ocupado=0, no output. Then a full frame is received normally.
- frameStart resync:
  - Send 4 bits, then frameStart together with bitValid(serialIn=1), then 6 more bits 0,1,0,1,0,1. Expected: dataRaw=7'b1010101.
  - Assert rst_n=0 mid-frame. Expected: all outputs 0 asynchronously.
- Saturation: with ERR_CNT_W=2, send 5 error frames. Expected: errCount sticks at 3.

Source files
------------

// File: rtl/receptor_hamming.sv
// ---------------------------------------------------------------------------
// receptor_hamming
//
// Purpose:
//   Front end of the Hamming(7,4) correction path. Collects a 7-bit codeword
//   from a strobed serial line (LSB first) and computes its 3-bit syndrome.
//   The result is handed to the correction stage through a one-deep
//   valid/ready buffer. The block also reports dropped frames (overflow),
//   aborts stalled frames (timeoutErr), and counts frames that are accepted
//   with a nonzero syndrome (errCount, saturating).
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   serialIn     in   serial codeword bit, qualified by bitValid
//   bitValid     in   one-cycle strobe for serialIn
//   frameStart   in   resynchronise: drop any partial frame
//   dataRaw      out  [6:0] captured codeword, bit i = Hamming position i+1
//   sindrome     out  [2:0] {s2,s1,s0}; erroneous position, 0 = clean
//   salidaValida out  output buffer holds an unconsumed frame
//   salidaLista  in   downstream ready
//   ocupado      out  high while a frame is being received
//   overflow     out  sticky: a completed frame was dropped
//   timeoutErr   out  one-cycle pulse when a stalled frame is aborted
//   errCount     out  [ERR_CNT_W-1:0] saturating count of erroneous frames
// ---------------------------------------------------------------------------
module receptor_hamming #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int ERR_CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 serialIn,
  input  logic                 bitValid,
  input  logic                 frameStart,
  output logic [6:0]           dataRaw,
  output logic [2:0]           sindrome,
  output logic                 salidaValida,
  input  logic                 salidaLista,
  output logic                 ocupado,
  output logic                 overflow,
  output logic                 timeoutErr,
  output logic [ERR_CNT_W-1:0] errCount
);

  // Idle counter only has to reach TIMEOUT_CYCLES-1.
  localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

  // Parity-check masks: syndrome bit k covers every position p (1..7) whose
  // binary index has bit k set. Packed as {s2, s1, s0}.
  localparam logic [20:0] SYN_MASKS = {7'b1111000, 7'b1100110, 7'b1010101};

  typedef enum logic {
    IDLE       = 1'b0,
    RECIBIENDO = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // Receive FSM state
  // -------------------------------------------------------------------------
  state_t            state_reg, state_next;
  logic [2:0]        bit_count_reg, bit_count_next;
  logic [IDLE_W-1:0] idle_count_reg, idle_count_next;
  // Only the first six bits are stored; the seventh is used directly from
  // serialIn on the completing edge.
  logic [5:0]        shift_reg, shift_next;

  logic              frame_done;
  logic              timeout_hit;

  // -------------------------------------------------------------------------
  // Output buffer and flags
  // -------------------------------------------------------------------------
  logic [6:0]           data_raw_reg;
  logic [2:0]           sindrome_reg;
  logic                 valid_reg;
  logic                 overflow_reg;
  logic                 timeout_reg;
  logic [ERR_CNT_W-1:0] err_count_reg;

  logic [6:0]           codeword;
  logic [2:0]           syn_calc;
  logic                 load;
  logic                 transfer;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    bit_count_next  = bit_count_reg;
    idle_count_next = idle_count_reg;
    shift_next      = shift_reg;
    frame_done      = 1'b0;
    timeout_hit     = 1'b0;

    if (frameStart) begin
      // Resync wins over everything the FSM would otherwise do. A strobe in
      // the same cycle opens the new frame with this bit.
      state_next      = IDLE;
      bit_count_next  = 3'd0;
      idle_count_next = '0;
      if (bitValid) begin
        shift_next     = {5'b0, serialIn};
        bit_count_next = 3'd1;
        state_next     = RECIBIENDO;
      end
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (bitValid) begin
            shift_next      = {5'b0, serialIn};
            bit_count_next  = 3'd1;
            idle_count_next = '0;
            state_next      = RECIBIENDO;
          end
        end

        RECIBIENDO: begin
          if (bitValid) begin
            idle_count_next = '0;
            if (bit_count_reg == 3'd6) begin
              frame_done     = 1'b1;
              bit_count_next = 3'd0;
              state_next     = IDLE;
            end else begin
              // Upper bits are zero since the frame opened, so OR-ing in
              // the new bit at its position is enough.
              shift_next     = shift_reg | (6'(serialIn) << bit_count_reg);
              bit_count_next = bit_count_reg + 3'd1;
            end
          end else if (idle_count_reg == IDLE_LAST) begin
            timeout_hit     = 1'b1;
            shift_next      = '0;
            bit_count_next  = 3'd0;
            idle_count_next = '0;
            state_next      = IDLE;
          end else begin
            idle_count_next = idle_count_reg + IDLE_W'(1);
          end
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      bit_count_reg  <= 3'd0;
      idle_count_reg <= '0;
      shift_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      bit_count_reg  <= bit_count_next;
      idle_count_reg <= idle_count_next;
      shift_reg      <= shift_next;
    end
  end

  // -------------------------------------------------------------------------
  // Syndrome of the complete word (stored six bits plus the live seventh)
  // -------------------------------------------------------------------------
  assign codeword = {serialIn, shift_reg};

  for (genvar gi = 0; gi < 3; gi++) begin : g_syndrome
    assign syn_calc[gi] = ^(codeword & SYN_MASKS[gi*7 +: 7]);
  end

  // A finished frame enters the buffer if it is empty or being drained on
  // this same edge; otherwise it is dropped and flagged.
  assign load     = frame_done && (!valid_reg || salidaLista);
  assign transfer = valid_reg && salidaLista;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_raw_reg  <= '0;
      sindrome_reg  <= '0;
      valid_reg     <= 1'b0;
      overflow_reg  <= 1'b0;
      timeout_reg   <= 1'b0;
      err_count_reg <= '0;
    end else begin
      timeout_reg <= timeout_hit;

      if (load) begin
        data_raw_reg <= codeword;
        sindrome_reg <= syn_calc;
        valid_reg    <= 1'b1;
        if ((syn_calc != 3'd0) && (err_count_reg != ERR_MAX)) begin
          err_count_reg <= err_count_reg + ERR_CNT_W'(1);
        end
      end else if (transfer) begin
        valid_reg <= 1'b0;
      end

      if (frame_done && !load) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign dataRaw      = data_raw_reg;
  assign sindrome     = sindrome_reg;
  assign salidaValida = valid_reg;
  assign overflow     = overflow_reg;
  assign timeoutErr   = timeout_reg;
  assign errCount     = err_count_reg;
  assign ocupado      = (state_reg == RECIBIENDO);

endmodule

// File: tb/tb_receptor_hamming.sv
// ---------------------------------------------------------------------------
// tb_receptor_hamming
//
// Self-checking bench for receptor_hamming. A behavioural model (bit queue,
// positional-XOR syndrome) is updated on every rising edge; every falling
// edge all DUT outputs are compared with it. Directed sequences add literal
// expectations; a long randomized phase follows.
// ---------------------------------------------------------------------------
module tb_receptor_hamming;

  localparam int T   = 12;
  localparam int ECW = 2;
  localparam int ERR_MAX = (1 << ECW) - 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           serialIn = 1'b0;
  logic           bitValid = 1'b0;
  logic           frameStart = 1'b0;
  logic           salidaLista = 1'b0;
  logic [6:0]     dataRaw;
  logic [2:0]     sindrome;
  logic           salidaValida;
  logic           ocupado;
  logic           overflow;
  logic           timeoutErr;
  logic [ECW-1:0] errCount;

  int n_checks = 0;
  int n_errors = 0;

  receptor_hamming #(.TIMEOUT_CYCLES(T), .ERR_CNT_W(ECW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .serialIn    (serialIn),
    .bitValid    (bitValid),
    .frameStart  (frameStart),
    .dataRaw     (dataRaw),
    .sindrome    (sindrome),
    .salidaValida(salidaValida),
    .salidaLista (salidaLista),
    .ocupado     (ocupado),
    .overflow    (overflow),
    .timeoutErr  (timeoutErr),
    .errCount    (errCount)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------
  bit         m_q[$];
  bit         m_in;
  int         m_idle;
  logic [6:0] m_data;
  logic [2:0] m_syn;
  bit         m_vld, m_ovf, m_to;
  int         m_err;

  task automatic model_reset();
    m_q.delete();
    m_in = 0; m_idle = 0; m_data = '0; m_syn = '0;
    m_vld = 0; m_ovf = 0; m_to = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit         complete = 0;
    logic [6:0] w = '0;
    logic [2:0] s = '0;
    bit         xfer;
    m_to = 0;
    if (frameStart) begin
      m_q.delete(); m_in = 0; m_idle = 0;
    end
    if (bitValid) begin
      m_q.push_back(serialIn);
      m_in = 1; m_idle = 0;
      if (m_q.size() == 7) begin
        complete = 1;
        // Syndrome = XOR of the (1-based) positions holding a one.
        for (int i = 0; i < 7; i++) begin
          w[i] = m_q[i];
          if (m_q[i]) s = s ^ 3'(i + 1);
        end
        m_q.delete(); m_in = 0;
      end
    end else if (m_in) begin
      m_idle++;
      if (m_idle == T) begin
        m_q.delete(); m_in = 0; m_idle = 0; m_to = 1;
      end
    end
    xfer = m_vld && salidaLista;
    if (complete && (!m_vld || salidaLista)) begin
      m_data = w; m_syn = s; m_vld = 1;
      if (s != 0 && m_err < ERR_MAX) m_err++;
    end else begin
      if (complete) m_ovf = 1;
      if (xfer) m_vld = 0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // ---------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("m.dataRaw",      32'(dataRaw),      32'(m_data));
    chk("m.sindrome",     32'(sindrome),     32'(m_syn));
    chk("m.salidaValida", 32'(salidaValida), 32'(m_vld));
    chk("m.ocupado",      32'(ocupado),      32'(m_in));
    chk("m.overflow",     32'(overflow),     32'(m_ovf));
    chk("m.timeoutErr",   32'(timeoutErr),   32'(m_to));
    chk("m.errCount",     32'(errCount),     32'(m_err));
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_bit(input bit b);
    bitValid = 1; serialIn = b;
    step();
    bitValid = 0; frameStart = 0;
  endtask

  task automatic send_word(input logic [6:0] w);
    for (int i = 0; i < 7; i++) send_bit(w[i]);
  endtask

  task automatic do_reset();
    rst_n = 0;
    step(); step();
    rst_n = 1;
    step();
  endtask

  logic [6:0] word;

  initial begin
    $display("tb_receptor_hamming: start");
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst.salidaValida", 32'(salidaValida), 32'd0);
    chk("rst.errCount",     32'(errCount),     32'd0);
    chk("rst.ocupado",      32'(ocupado),      32'd0);
    step();

    // Clean frame 1010101
    salidaLista = 1;
    send_word(7'b1010101);
    @(negedge clk);
    chk("clean.valid", 32'(salidaValida), 32'd1);
    chk("clean.data",  32'(dataRaw),      32'h55);
    chk("clean.syn",   32'(sindrome),     32'd0);
    chk("clean.err",   32'(errCount),     32'd0);
    step();
    @(negedge clk);
    chk("clean.valid_fall", 32'(salidaValida), 32'd0);
    $display("txn clean frame done");

    // Single-bit error: position 5 (index 4) flipped
    send_word(7'b1000101);
    @(negedge clk);
    chk("err1.data", 32'(dataRaw),  32'h45);
    chk("err1.syn",  32'(sindrome), 32'd5);
    chk("err1.err",  32'(errCount), 32'd1);
    step();
    $display("txn single-bit error done");

    // Backpressure and overflow
    do_reset();
    salidaLista = 0;
    send_word(7'b1010101);
    send_word(7'b0000000);
    @(negedge clk);
    chk("bp.valid", 32'(salidaValida), 32'd1);
    chk("bp.data",  32'(dataRaw),      32'h55);
    chk("bp.ovf",   32'(overflow),     32'd1);
    chk("bp.err",   32'(errCount),     32'd0);
    salidaLista = 1;
    step();
    @(negedge clk);
    chk("bp.valid_fall", 32'(salidaValida), 32'd0);
    chk("bp.ovf_sticky", 32'(overflow),     32'd1);
    $display("txn backpressure/overflow done");

    // Timeout
    send_bit(1); send_bit(0); send_bit(1);
    for (int i = 0; i < T; i++) step();
    @(negedge clk);
    chk("to.pulse",   32'(timeoutErr),   32'd1);
    chk("to.ocupado", 32'(ocupado),      32'd0);
    chk("to.valid",   32'(salidaValida), 32'd0);
    step();
    @(negedge clk);
    chk("to.pulse_end", 32'(timeoutErr), 32'd0);
    send_word(7'b0110011);
    @(negedge clk);
    chk("to.next_valid", 32'(salidaValida), 32'd1);
    chk("to.next_data",  32'(dataRaw),      32'h33);
    step();
    $display("txn timeout done");

    // frameStart resync
    send_bit(1); send_bit(1); send_bit(0); send_bit(0);
    frameStart = 1;
    send_bit(1);
    send_bit(0); send_bit(1); send_bit(0); send_bit(1); send_bit(0); send_bit(1);
    @(negedge clk);
    chk("fs.data",  32'(dataRaw),      32'h55);
    chk("fs.valid", 32'(salidaValida), 32'd1);
    step();
    $display("txn frameStart resync done");

    // Saturation of errCount
    do_reset();
    for (int k = 0; k < 5; k++) send_word(7'b1000101);
    @(negedge clk);
    chk("sat.err", 32'(errCount), 32'd3);
    step();
    $display("txn saturation done");

    // Asynchronous reset mid-frame
    send_bit(1); send_bit(1); send_bit(0);
    rst_n = 0;
    #1;
    chk("arst.ocupado",  32'(ocupado),      32'd0);
    chk("arst.valid",    32'(salidaValida), 32'd0);
    chk("arst.err",      32'(errCount),     32'd0);
    chk("arst.ovf",      32'(overflow),     32'd0);
    chk("arst.data",     32'(dataRaw),      32'd0);
    step(); step();
    rst_n = 1;
    step();
    $display("txn async reset done");

    // Randomized traffic
    for (int c = 0; c < 6000; c++) begin
      int pbv;
      pbv = ((c / 300) % 2 == 0) ? 70 : 4;
      bitValid    = ($urandom_range(0, 99) < pbv);
      serialIn    = $urandom_range(0, 1) == 1;
      frameStart  = ($urandom_range(0, 99) == 0);
      salidaLista = ($urandom_range(0, 99) < 60);
      rst_n       = ($urandom_range(0, 999) >= 2);
      step();
      if (c % 500 == 499) $display("txn random block %0d done", c / 500);
    end
    rst_n = 1; bitValid = 0; frameStart = 0;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
